imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Decodes the immediate field of a RISC-V instruction and buffers the result,
// together with the branch/jump target (pc + imm), in a two-entry skid buffer
// with valid/ready handshakes on both sides.
//
// Parameters
//   XLEN        datapath width, 32 or 64
//
// Optional feature
//   IMM_GEN_ZICSR_EN  when defined, SYSTEM instructions with funct3[2]=1
//                     (csrr*i) decode as format Z with the 5-bit zimm field,
//                     zero-extended. When undefined every SYSTEM instruction
//                     decodes as format 0 with a zero immediate.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous discard of every buffered entry
//   in_valid     upstream entry present
//   in_ready     buffer can accept an entry (not FULL)
//   in_instr     32-bit instruction word
//   in_pc        instruction address
//   out_valid    head entry present (not EMPTY)
//   out_ready    downstream accepts the head entry
//   out_imm      decoded immediate of the head entry
//   out_fmt      0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_target   head pc + head imm, modulo 2^XLEN
//   out_illegal  head instruction had instr[1:0] != 2'b11
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Immediate decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  entry_t          dec_entry;

  // Width casts of signed operands sign-extend from instr[31] to XLEN.
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));

  always_comb begin
    dec_entry         = '0;
    dec_entry.pc      = in_pc;
    dec_entry.imm     = '0;
    dec_entry.fmt     = FMT_NONE;
    dec_entry.illegal = 1'b0;

    if (in_instr[1:0] != 2'b11) begin
      // Compressed/illegal encodings carry no immediate regardless of opcode.
      dec_entry.illegal = 1'b1;
    end else begin
      unique case (in_instr[6:0])
        OP_IMM, OP_LOAD, OP_JALR: begin
          dec_entry.fmt = FMT_I;
          dec_entry.imm = imm_i;
        end
        OP_IMM32: begin
          // The *W immediate ops only exist on RV64.
          if (XLEN == 64) begin
            dec_entry.fmt = FMT_I;
            dec_entry.imm = imm_i;
          end
        end
        OP_STORE: begin
          dec_entry.fmt = FMT_S;
          dec_entry.imm = imm_s;
        end
        OP_BRANCH: begin
          dec_entry.fmt = FMT_B;
          dec_entry.imm = imm_b;
        end
        OP_LUI, OP_AUIPC: begin
          dec_entry.fmt = FMT_U;
          dec_entry.imm = imm_u;
        end
        OP_JAL: begin
          dec_entry.fmt = FMT_J;
          dec_entry.imm = imm_j;
        end
        OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
          // funct3[2] selects the csrr*i forms whose rs1 field is a zimm.
          if (in_instr[14]) begin
            dec_entry.fmt = FMT_Z;
            dec_entry.imm = XLEN'(in_instr[19:15]);
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer: head_reg drives the outputs, tail_reg holds the
  // second entry while FULL. in_ready depends on the state only, so there is
  // no combinational path from out_ready to in_ready.
  // ---------------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;
  entry_t head_reg;
  entry_t tail_reg;
  logic   push;
  logic   pop;
  logic   load_head;
  logic   head_from_tail;
  logic   load_tail;

  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_head      = 1'b0;
    head_from_tail = 1'b0;
    load_tail      = 1'b0;

    if (flush) begin
      // Same-cycle push and pop are both dropped.
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (push) begin
            state_next = ONE;
            load_head  = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_head = 1'b1;
          end else if (push) begin
            state_next = FULL;
            load_tail  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // No push is possible here because in_ready is low.
          if (pop) begin
            state_next     = ONE;
            head_from_tail = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (load_head) begin
        head_reg <= dec_entry;
      end else if (head_from_tail) begin
        head_reg <= tail_reg;
      end
      if (load_tail) begin
        tail_reg <= dec_entry;
      end
    end
  end

  // The target is formed from the stored pc and stored imm of the head entry,
  // keeping the adder off the input decode path.
  assign out_imm     = head_reg.imm;
  assign out_fmt     = head_reg.fmt;
  assign out_illegal = head_reg.illegal;
  assign out_target  = head_reg.pc + head_reg.imm;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and checks
// both against a queue-based reference model on every cycle, plus directed
// scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_target(tgt32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_target(tgt64), .out_illegal(ill64)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: the buffer is a queue of raw (instr, pc) pairs; the
  // immediate is computed arithmetically from field weights when needed.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  ent_t q[$];

  function automatic logic [2:0] m_fmt(logic [31:0] i, int xlen);
    if (i[1:0] != 2'b11) return 3'd0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 3'd1;
      7'h1B:               return (xlen == 64) ? 3'd1 : 3'd0;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6F:               return 3'd5;
`ifdef IMM_GEN_ZICSR_EN
      7'h73:               return i[14] ? 3'd6 : 3'd0;
`endif
      default:             return 3'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_imm(logic [31:0] i, int xlen);
    longint      v;
    logic [63:0] r;
    v = 0;
    case (m_fmt(i, xlen))
      3'd1: begin
        v = longint'(i[31:20]);
        if (i[31]) v = v - 4096;
      end
      3'd2: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (i[31]) v = v - 4096;
      end
      3'd3: begin
        v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (i[31]) v = v - 4096;
      end
      3'd4: begin
        v = longint'(i[31:12]) * 4096;
        if (i[31]) v = v - 64'sh1_0000_0000;
      end
      3'd5: begin
        v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (i[31]) v = v - 1048576;
      end
      3'd6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    r = v;
    return (xlen == 32) ? (r & 64'hFFFF_FFFF) : r;
  endfunction

  function automatic logic [63:0] m_target(logic [31:0] i, logic [63:0] pc, int xlen);
    logic [63:0] s;
    s = pc + m_imm(i, xlen);
    return (xlen == 32) ? (s & 64'hFFFF_FFFF) : s;
  endfunction

  // Single compare process: handshake flags every cycle, head data whenever
  // the model holds an entry.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("in_ready32", rdy32, q.size() < 2);
      check("in_ready64", rdy64, q.size() < 2);
      check("out_valid32", vld32, q.size() > 0);
      check("out_valid64", vld64, q.size() > 0);
      if (q.size() > 0) begin
        check("imm32", imm32, m_imm(q[0].instr, 32));
        check("fmt32", fmt32, m_fmt(q[0].instr, 32));
        check("target32", tgt32, m_target(q[0].instr, q[0].pc, 32));
        check("illegal32", ill32, q[0].instr[1:0] != 2'b11);
        check("imm64", imm64, m_imm(q[0].instr, 64));
        check("fmt64", fmt64, m_fmt(q[0].instr, 64));
        check("target64", tgt64, m_target(q[0].instr, q[0].pc, 64));
        check("illegal64", ill64, q[0].instr[1:0] != 2'b11);
      end
    end
  end

  // One clock cycle: entered just after a falling edge, returns just after
  // the next falling edge with the model updated for the rising edge between.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic ordy, input logic fl);
    bit pushed;
    bit popped;
    ent_t e;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    pushed = v && (q.size() < 2);
    popped = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (popped) void'(q.pop_front());
      if (pushed) begin
        e.instr = ins;
        e.pc    = pc;
        q.push_back(e);
      end
    end
    @(negedge clk);
    $display("cycle v=%0b instr=%08h pc=%016h ordy=%0b flush=%0b depth=%0d",
             v, ins, pc, ordy, fl, q.size());
  endtask

  logic [6:0] ops [0:11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h1B, 7'h73, 7'h33, 7'h0F};

  initial begin
    logic [31:0] ri;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_pc     = '0;

    // Pin the model against hand-computed values.
    check("model_addi_imm32", m_imm(32'hFFF0_0093, 32), 64'hFFFF_FFFF);
    check("model_jal_imm64", m_imm(32'h8000_00EF, 64), 64'hFFFF_FFFF_FFF0_0000);
    check("model_jal_tgt64", m_target(32'h8000_00EF, 64'h1000_0000, 64), 64'h0FF0_0000);
    check("model_sw_imm32", m_imm(32'hFE11_2E23, 32), 64'hFFFF_FFFC);
    check("model_lui_imm64", m_imm(32'h8000_0037, 64), 64'hFFFF_FFFF_8000_0000);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid32", vld32, 1'b0);
    check("rst_out_valid64", vld64, 1'b0);
    check("rst_imm64", imm64, 64'h0);
    check("rst_target64", tgt64, 64'h0);
    check("rst_fmt32", fmt32, 3'd0);
    check("rst_illegal32", ill32, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready32", rdy32, 1'b1);
    check("rst_in_ready64", rdy64, 1'b1);
    chk_en = 1'b1;
    @(negedge clk);

    // addi x1, x0, -1 at pc 0x100: visible one cycle later
    step(1'b1, 32'hFFF0_0093, 64'h100, 1'b1, 1'b0);
    check("addi_imm32", imm32, 32'hFFFF_FFFF);
    check("addi_fmt32", fmt32, 3'd1);
    check("addi_target32", tgt32, 32'h0000_00FF);
    check("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);

    // jal with minimum offset
    step(1'b1, 32'h8000_00EF, 64'h1000_0000, 1'b1, 1'b0);
    check("jal_imm64", imm64, 64'hFFFF_FFFF_FFF0_0000);
    check("jal_fmt64", fmt64, 3'd5);
    check("jal_target64", tgt64, 64'h0000_0000_0FF0_0000);
    step(1'b1, 32'h8000_00EF, 64'hFFFF_FFFF_1000_0000, 1'b1, 1'b0);
    check("jal_target64_hi", tgt64, 64'hFFFF_FFFF_0FF0_0000);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("drained", vld32, 1'b0);

    // Back-pressure: three entries offered, the third is held upstream
    step(1'b1, 32'h0010_0093, 64'h10, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 64'h20, 1'b0, 1'b0);
    check("full_in_ready32", rdy32, 1'b0);
    check("full_in_ready64", rdy64, 1'b0);
    step(1'b1, 32'h0030_0093, 64'h30, 1'b0, 1'b0);
    check("held_head_imm", imm32, 32'd1);
    step(1'b1, 32'h0030_0093, 64'h30, 1'b1, 1'b0);
    check("order_second", imm32, 32'd2);
    step(1'b1, 32'h0030_0093, 64'h30, 1'b1, 1'b0);
    check("order_third", imm32, 32'd3);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("order_empty", vld32, 1'b0);

    // Flush while FULL with in_valid high
    step(1'b1, 32'h0040_0093, 64'h40, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0093, 64'h50, 1'b0, 1'b0);
    step(1'b1, 32'h0060_0093, 64'h60, 1'b0, 1'b1);
    check("flush_out_valid", vld64, 1'b0);
    check("flush_in_ready", rdy64, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("flush_no_emerge", vld64, 1'b0);
    // Flush from ONE drops the same-cycle push
    step(1'b1, 32'h0070_0093, 64'h70, 1'b0, 1'b0);
    step(1'b1, 32'h0080_0093, 64'h80, 1'b0, 1'b1);
    check("flush_one_push", vld32, 1'b0);

    // csrrwi with zimm 15
    step(1'b1, 32'h3007_D073, 64'h200, 1'b1, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
    check("csr_fmt", fmt32, 3'd6);
    check("csr_imm", imm32, 32'd15);
    check("csr_target", tgt32, 32'h20F);
`else
    check("csr_fmt", fmt32, 3'd0);
    check("csr_imm", imm32, 32'd0);
    check("csr_target", tgt32, 32'h200);
`endif

    // All-zero word is illegal
    step(1'b1, 32'h0000_0000, 64'h300, 1'b1, 1'b0);
    check("zero_illegal", ill64, 1'b1);
    check("zero_imm", imm64, 64'h0);
    check("zero_fmt", fmt64, 3'd0);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) ri[1:0] = 2'($urandom_range(0, 2));
      step($urandom_range(0, 3) != 0, ri, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    // Reset asserted mid-stream while FULL
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 32'hABC0_0013, 64'h500, 1'b0, 1'b0);
    step(1'b1, 32'h1230_0013, 64'h600, 1'b0, 1'b0);
    check("pre_rst_full", rdy32, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid32", vld32, 1'b0);
    check("mid_rst_out_valid64", vld64, 1'b0);
    check("mid_rst_imm32", imm32, 32'h0);
    check("mid_rst_target64", tgt64, 64'h0);
    check("mid_rst_fmt64", fmt64, 3'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", rdy32, 1'b1);
    check("post_rst_out_valid", vld64, 1'b0);
    @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 32'h0000_0063 | ($urandom & 32'hFFFF_FF80), {32'h0, $urandom},
           $urandom_range(0, 1) != 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
